draw_number: RTL and testbench
==============================

// Module: draw_number
// PURPOSE
// Upstream sequencer for draw_char: prints an unsigned binary value as right-aligned decimal text.
// Converts the value to BCD (sequential double-dabble), then issues one draw_char command per digit.
// Each command waits for draw_char's done pulse before the next is issued.
// Sits between application logic (score/counter display) and the draw_char -> VGA RAM path.
// PARAMETERS
// PIXEL_X_WIDTH   10   x coordinate width
// PIXEL_Y_WIDTH   9    y coordinate width
// COLOR_ID_WIDTH  8    colour index width
// VALUE_WIDTH     17   binary input width
// DIGITS          5    decimal field width; MAX_VAL = 10^DIGITS-1 (localparam)
// PORTS
// clk        in   1    clock
// rst        in   1    reset, synchronous, active-high
// start      in   1    1-cycle request; ignored while busy
// value      in   VALUE_WIDTH  number to print (sampled on start)
// x          in   PIXEL_X_WIDTH  left x of field (sampled on start)
// y          in   PIXEL_Y_WIDTH  top y of field (sampled on start)
// size       in   4    glyph scale (sampled on start)
// lz_blank   in   1    1 = suppress leading zeros (sampled on start)
// fg, bg     in   COLOR_ID_WIDTH each  colours (sampled on start)
// busy       out  1    high from cycle after accepted start until done
// done       out  1    1-cycle pulse after last digit completes
// ovf        out  1    value > MAX_VAL on last accepted start (held until next start)
// cx, cy     out  PIXEL_X/Y_WIDTH  draw_char x/y
// ccode      out  8    ASCII digit 8'h30..8'h39
// csize      out  4    latched size
// cmode      out  2    constant 2'b10 (full load)
// cfg, cbg   out  COLOR_ID_WIDTH  latched colours
// cvld       out  1    draw_char idata_vld, 1-cycle pulse
// cdone      in   1    draw_char odone pulse
// BEHAVIOUR
// - Reset: state IDLE; busy/done/ovf/cvld=0; cx,cy,ccode,csize,cfg,cbg=0; cmode=2'b10 always.
//   rst mid-operation aborts immediately; no further cvld; a pending cdone is ignored.
// - FSM: IDLE -> CONV -> ISSUE -> WAIT -> GAP -> ISSUE ... -> FIN -> IDLE.
// - IDLE: start=1 latches inputs, clears BCD; if value>MAX_VAL, ovf=1 and value replaced by MAX_VAL.
// - CONV: exactly VALUE_WIDTH cycles; each cycle adds 3 to every BCD nibble >=5, then shifts in the next MSB.
// - ISSUE: digit index k=0..DIGITS-1, most significant first.
//   Digit k is blank if lz_blank=1, all digits 0..k are zero, and k<DIGITS-1 (last digit is always drawn).
//   Blank: no cvld; go to GAP.
//   Otherwise: cvld=1 for one cycle, ccode=8'h30+digit, cx=x0+k*PITCH, cy=y0; go to WAIT.
// - PITCH = 6*(size+1), computed at PIXEL_X_WIDTH bits; x overflow wraps (caller's responsibility).
// - WAIT: cx/cy/ccode/csize/cfg/cbg held stable; stay until cdone=1; cdone seen in any other state is ignored.
// - GAP: one idle cycle (draw_char needs it to reload); k++; if k==DIGITS go to FIN, else ISSUE.
// - FIN: done=1 for one cycle, busy drops the same cycle; go to IDLE. Next start is accepted in IDLE.
// - Latency: first cvld exactly VALUE_WIDTH+1 cycles after start edge; busy high that whole span.
// - start while busy: dropped, latched values unchanged.
// - start coincident with rst: rst wins.
// TESTING
// - value=12345, x=100, y=50, size=0, lz_blank=0 -> 5 cvld: ccode 31..35, cx 100,106,112,118,124, cy=50; then done; ovf=0.
// - value=42, lz_blank=1, size=1 -> only 2 cvld: ccode 34 (cx=x+36), 32 (cx=x+48); 3 blanks with no cvld.
// - value=0, lz_blank=1 -> single cvld ccode=8'h30 at cx=x+4*PITCH; done follows.
// - value=131071 -> ovf=1; five cvld, all ccode=8'h39.
// - cdone held off 200 cycles -> outputs stable, no second cvld until cdone; second start during busy ignored.
// - rst asserted in WAIT -> next cycle busy=0, cvld=0; later cdone produces no done; new start works normally.

Source files
------------

// File: rtl/draw_number.sv
// Prints an unsigned binary value as right-aligned decimal text by converting it to BCD
// (sequential double-dabble) and handing one digit at a time to draw_char.
module draw_number #(
    parameter int PIXEL_X_WIDTH  = 10,
    parameter int PIXEL_Y_WIDTH  = 9,
    parameter int COLOR_ID_WIDTH = 8,
    parameter int VALUE_WIDTH    = 17,
    parameter int DIGITS         = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [VALUE_WIDTH-1:0]    value,
    input  logic [PIXEL_X_WIDTH-1:0]  x,
    input  logic [PIXEL_Y_WIDTH-1:0]  y,
    input  logic [3:0]                size,
    input  logic                      lz_blank,
    input  logic [COLOR_ID_WIDTH-1:0] fg,
    input  logic [COLOR_ID_WIDTH-1:0] bg,
    output logic                      busy,
    output logic                      done,
    output logic                      ovf,
    output logic [PIXEL_X_WIDTH-1:0]  cx,
    output logic [PIXEL_Y_WIDTH-1:0]  cy,
    output logic [7:0]                ccode,
    output logic [3:0]                csize,
    output logic [1:0]                cmode,
    output logic [COLOR_ID_WIDTH-1:0] cfg,
    output logic [COLOR_ID_WIDTH-1:0] cbg,
    output logic                      cvld,
    input  logic                      cdone
);

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

    localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam int K_W   = $clog2(DIGITS + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CONV, S_ISSUE, S_WAIT, S_GAP, S_FIN
    } state_t;

    state_t state, state_nxt;

    logic [VALUE_WIDTH-1:0]    val_sr;
    logic [BCD_W-1:0]          bcd;
    logic [BCD_W-1:0]          bcd_adj;
    logic [CNT_W-1:0]          cnt;
    logic [K_W-1:0]            k;
    logic                      seen_nz;
    logic                      lz_r;
    logic [PIXEL_X_WIDTH-1:0]  x_r;
    logic [PIXEL_Y_WIDTH-1:0]  y_r;
    logic [3:0]                size_r;
    logic [COLOR_ID_WIDTH-1:0] fg_r;
    logic [COLOR_ID_WIDTH-1:0] bg_r;

    logic                      over;
    logic                      conv_last;
    logic                      last_digit;
    logic                      blank;
    logic [3:0]                digit;
    logic [PIXEL_X_WIDTH-1:0]  pitch;

    assign over       = 64'(value) > MAX_VAL;
    assign conv_last  = (cnt == CNT_W'(VALUE_WIDTH - 1));
    assign last_digit = (k == K_W'(DIGITS - 1));
    // The digit under issue is always the top nibble; GAP shifts the next one up.
    assign digit      = bcd[BCD_W-1 -: 4];
    assign blank      = lz_r && !seen_nz && (digit == 4'd0) && !last_digit;
    assign pitch      = (PIXEL_X_WIDTH'(size_r) + PIXEL_X_WIDTH'(1)) * PIXEL_X_WIDTH'(6);

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_CONV;
            S_CONV:  if (conv_last) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = blank ? S_GAP : S_WAIT;
            S_WAIT:  if (cdone) state_nxt = S_GAP;
            S_GAP:   state_nxt = last_digit ? S_FIN : S_ISSUE;
            S_FIN:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            val_sr  <= '0;
            bcd     <= '0;
            cnt     <= '0;
            k       <= '0;
            seen_nz <= 1'b0;
            lz_r    <= 1'b0;
            x_r     <= '0;
            y_r     <= '0;
            size_r  <= '0;
            fg_r    <= '0;
            bg_r    <= '0;
            ovf     <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: if (start) begin
                    val_sr  <= over ? MAX_VAL[VALUE_WIDTH-1:0] : value;
                    ovf     <= over;
                    bcd     <= '0;
                    cnt     <= '0;
                    k       <= '0;
                    seen_nz <= 1'b0;
                    lz_r    <= lz_blank;
                    x_r     <= x;
                    y_r     <= y;
                    size_r  <= size;
                    fg_r    <= fg;
                    bg_r    <= bg;
                end
                S_CONV: begin
                    bcd    <= {bcd_adj[BCD_W-2:0], val_sr[VALUE_WIDTH-1]};
                    val_sr <= val_sr << 1;
                    cnt    <= cnt + CNT_W'(1);
                end
                S_ISSUE: if (digit != 4'd0) seen_nz <= 1'b1;
                S_GAP: begin
                    bcd <= bcd << 4;
                    k   <= k + K_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Command fields come straight from latched state, so they hold still for the whole WAIT.
    assign busy  = (state == S_CONV) || (state == S_ISSUE) || (state == S_WAIT) || (state == S_GAP);
    assign done  = (state == S_FIN);
    assign cvld  = (state == S_ISSUE) && !blank;
    assign cx    = x_r + PIXEL_X_WIDTH'(k) * pitch;
    assign cy    = y_r;
    assign ccode = ((state == S_ISSUE) || (state == S_WAIT)) ? (8'h30 + {4'h0, digit}) : 8'h00;
    assign csize = size_r;
    assign cmode = 2'b10;
    assign cfg   = fg_r;
    assign cbg   = bg_r;

endmodule

// File: tb/tb_draw_number.sv
// Directed bench for draw_number: plays draw_char's side of the handshake and checks the
// digit stream, positions, latency, overflow, busy-time start rejection and mid-run reset.
module tb_draw_number;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [16:0] value;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [3:0]  size;
    logic        lz_blank;
    logic [7:0]  fg, bg;
    logic        busy, done, ovf, cvld, cdone;
    logic [9:0]  cx;
    logic [8:0]  cy;
    logic [7:0]  ccode;
    logic [3:0]  csize;
    logic [1:0]  cmode;
    logic [7:0]  cfg, cbg;

    int tests    = 0;
    int failures = 0;

    logic [7:0]  rec_code [8];
    logic [9:0]  rec_cx   [8];
    logic [8:0]  rec_cy   [8];
    logic [46:0] rec_snap [8];
    int          n_cvld, first_cyc, wait_err, busy_err;
    logic        got_done, done_after, busy_after;

    always #5 clk = ~clk;

    draw_number dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .x(x), .y(y),
        .size(size), .lz_blank(lz_blank), .fg(fg), .bg(bg),
        .busy(busy), .done(done), .ovf(ovf), .cx(cx), .cy(cy), .ccode(ccode),
        .csize(csize), .cmode(cmode), .cfg(cfg), .cbg(cbg), .cvld(cvld), .cdone(cdone)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One full print: start, answer each cvld with cdone after `delay` cycles, optionally
    // fire a stray start at cycle `inj`, and stop at done (or at the cycle budget).
    task automatic run_op(input logic [16:0] v, input logic [9:0] px, input logic [8:0] py,
                          input logic [3:0] sz, input logic lz, input int delay, input int inj);
        int pending;
        logic [46:0] snap;
        pending = 0; n_cvld = 0; first_cyc = -1; wait_err = 0; busy_err = 0;
        got_done = 1'b0; done_after = 1'bx; busy_after = 1'bx;
        @(negedge clk);
        value = v; x = px; y = py; size = sz; lz_blank = lz; fg = 8'hA5; bg = 8'h3C;
        start = 1'b1;
        for (int n = 1; n <= 3000; n++) begin
            @(negedge clk);
            start = (n == inj);
            if (n == inj) begin
                value = 17'h1FFFF; x = 10'd0; y = 9'd0; size = 4'hF; fg = 8'h00; bg = 8'h00;
            end
            snap = {cx, cy, ccode, csize, cfg, cbg};
            if (done) begin
                got_done = 1'b1;
                if (busy) busy_err++;
                break;
            end
            if (!busy) busy_err++;
            if (pending > 0 && (cvld || snap != rec_snap[n_cvld-1])) wait_err++;
            cdone = 1'b0;
            if (pending > 0) begin
                pending--;
                if (pending == 0) cdone = 1'b1;
            end
            if (cvld && pending == 0 && !cdone) begin
                if (first_cyc < 0) first_cyc = n;
                if (n_cvld < 8) begin
                    rec_code[n_cvld] = ccode;
                    rec_cx[n_cvld]   = cx;
                    rec_cy[n_cvld]   = cy;
                    rec_snap[n_cvld] = snap;
                end
                n_cvld++;
                pending = delay;
            end
        end
        cdone = 1'b0;
        start = 1'b0;
        if (got_done) begin
            @(negedge clk);
            done_after = done;
            busy_after = busy;
        end
    endtask

    initial begin
        int   errs;
        logic saw;
        rst = 1'b1; start = 1'b0; value = '0; x = '0; y = '0; size = '0;
        lz_blank = 1'b0; fg = '0; bg = '0; cdone = 1'b0;
        repeat (3) @(negedge clk);

        check("rst busy",  busy, 0);
        check("rst done",  done, 0);
        check("rst ovf",   ovf, 0);
        check("rst cvld",  cvld, 0);
        check("rst cx",    cx, 0);
        check("rst cy",    cy, 0);
        check("rst ccode", ccode, 0);
        check("rst csize", csize, 0);
        check("rst cfg",   {cfg, cbg}, 0);
        check("rst cmode", cmode, 2);
        rst = 1'b0;

        // 12345, no blanking, size 0 -> pitch 6
        run_op(17'd12345, 10'd100, 9'd50, 4'd0, 1'b0, 2, 0);
        check("t1 done",    got_done, 1);
        check("t1 n_cvld",  n_cvld, 5);
        check("t1 latency", first_cyc, 18);
        for (int i = 0; i < 5; i++) begin
            check("t1 ccode", rec_code[i], 8'h31 + 8'(i));
            check("t1 cx",    rec_cx[i], 100 + 6 * i);
            check("t1 cy",    rec_cy[i], 50);
        end
        check("t1 ovf",       ovf, 0);
        check("t1 csize/col", {csize, cfg, cbg}, {4'd0, 8'hA5, 8'h3C});
        check("t1 wait",      wait_err, 0);
        check("t1 busy",      busy_err, 0);
        check("t1 done 1cyc", {done_after, busy_after}, 2'b00);

        // 42 with blanking, size 1 -> pitch 12; three blanks add six cycles before the first cvld
        run_op(17'd42, 10'd20, 9'd7, 4'd1, 1'b1, 1, 0);
        check("t2 done",    got_done, 1);
        check("t2 n_cvld",  n_cvld, 2);
        check("t2 latency", first_cyc, 24);
        check("t2 code0",   rec_code[0], 8'h34);
        check("t2 cx0",     rec_cx[0], 56);
        check("t2 code1",   rec_code[1], 8'h32);
        check("t2 cx1",     rec_cx[1], 68);
        check("t2 csize",   csize, 1);

        // 0 with blanking: only the last digit is drawn; size 2 -> pitch 18
        run_op(17'd0, 10'd0, 9'd3, 4'd2, 1'b1, 1, 0);
        check("t3 done",    got_done, 1);
        check("t3 n_cvld",  n_cvld, 1);
        check("t3 latency", first_cyc, 26);
        check("t3 code",    rec_code[0], 8'h30);
        check("t3 cx",      rec_cx[0], 72);

        // Over range: clamped to 99999; size 3 -> pitch 24, x wraps past 1023
        run_op(17'd131071, 10'd1000, 9'd511, 4'd3, 1'b0, 3, 0);
        check("t4 done",   got_done, 1);
        check("t4 ovf",    ovf, 1);
        check("t4 n_cvld", n_cvld, 5);
        for (int i = 0; i < 5; i++) check("t4 ccode", rec_code[i], 8'h39);
        check("t4 cx0",    rec_cx[0], 1000);
        check("t4 cx1",    rec_cx[1], 0);
        check("t4 cx4",    rec_cx[4], 72);

        // Exactly MAX_VAL is not an overflow
        run_op(17'd99999, 10'd0, 9'd0, 4'd0, 1'b1, 1, 0);
        check("t5 ovf",    ovf, 0);
        check("t5 n_cvld", n_cvld, 5);

        // Inner zeros after the first non-zero digit are drawn
        run_op(17'd100, 10'd10, 9'd0, 4'd0, 1'b1, 1, 0);
        check("t6 n_cvld", n_cvld, 3);
        check("t6 codes",  {rec_code[0], rec_code[1], rec_code[2]}, {8'h31, 8'h30, 8'h30});
        check("t6 cx0",    rec_cx[0], 22);

        // Slow draw_char plus a stray start while busy
        run_op(17'd12345, 10'd100, 9'd50, 4'd0, 1'b0, 200, 50);
        check("t7 done",   got_done, 1);
        check("t7 n_cvld", n_cvld, 5);
        check("t7 wait",   wait_err, 0);
        check("t7 busy",   busy_err, 0);
        check("t7 codes",  {rec_code[0], rec_code[4]}, {8'h31, 8'h35});
        check("t7 cx4",    rec_cx[4], 124);
        check("t7 ovf",    ovf, 0);
        check("t7 color",  {csize, cfg, cbg}, {4'd0, 8'hA5, 8'h3C});

        // Reset while waiting for cdone
        @(negedge clk);
        value = 17'd12345; x = 10'd100; y = 9'd50; size = 4'd0; lz_blank = 1'b0; start = 1'b1;
        saw = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            start = 1'b0;
            if (cvld) begin saw = 1'b1; break; end
        end
        check("t8 cvld seen", saw, 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t8 busy", busy, 0);
        check("t8 cvld", cvld, 0);
        check("t8 cx",   cx, 0);
        cdone = 1'b1;
        errs = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            cdone = 1'b0;
            if (done || cvld || busy) errs++;
        end
        check("t8 quiet", errs, 0);

        run_op(17'd7, 10'd3, 9'd4, 4'd0, 1'b0, 1, 0);
        check("t8 n_cvld", n_cvld, 5);
        check("t8 codes",  {rec_code[0], rec_code[4]}, {8'h30, 8'h37});
        check("t8 cx4",    rec_cx[4], 27);

        // start coincident with rst is dropped
        @(negedge clk);
        rst = 1'b1; start = 1'b1; value = 17'd5;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        check("t9 busy", busy, 0);
        @(negedge clk);
        check("t9 busy later", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
